// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard/sequencing controller: decides IF/ID advance/hold/squash,
// PC write gating, ID/EX bubbles, branch flush and call squash, and halt latching.
//
// state   | meaning
// RUN     | normal issue, hazards checked in priority order
// FLUSH   | squashing wrong-path fetches after a taken branch
// CALL_SQ | cycle after a call pulse; call and halt detection masked
// HALT    | core halted until reset
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [3:0]  CALL_OP      = 4'hD,
    parameter logic [15:0] HLT_INSTR    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ifid_instr,
    input  logic        idex_mem_read,
    input  logic [3:0]  idex_rd,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        data_hazard,
    output logic        PC_hazard,
    output logic        call,
    output logic        pc_write_en,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, FLUSH, CALL_SQ, HALT} state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;

    logic load_use, is_halt, is_call;
    logic dh, pch, call_c, pcwe, flush;

    always_comb begin
        load_use = idex_mem_read && (idex_rd != 4'd0) &&
                   ((idex_rd == ifid_instr[7:4]) || (idex_rd == ifid_instr[3:0]));
        is_halt  = (ifid_instr == HLT_INSTR);
        is_call  = (ifid_instr[15:12] == CALL_OP);

        state_d = state_q;
        cnt_d   = cnt_q;
        dh      = 1'b0;
        pch     = 1'b0;
        call_c  = 1'b0;
        pcwe    = 1'b1;
        flush   = 1'b0;

        case (state_q)
            RUN, CALL_SQ: begin
                // mem_busy keeps CALL_SQ so a frozen call is not pulsed again
                if (mem_busy) begin
                    dh   = 1'b1;
                    pcwe = 1'b0;
                end else begin
                    state_d = RUN;
                    if (branch_taken) begin
                        pch   = 1'b1;
                        flush = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_d = FLUSH;
                            cnt_d   = FLUSH_RELOAD;
                        end
                    end else if (load_use) begin
                        dh    = 1'b1;
                        pcwe  = 1'b0;
                        flush = 1'b1;
                    end else if (state_q == RUN && is_halt) begin
                        dh      = 1'b1;
                        pcwe    = 1'b0;
                        flush   = 1'b1;
                        state_d = HALT;
                    end else if (state_q == RUN && is_call) begin
                        call_c  = 1'b1;
                        state_d = CALL_SQ;
                    end
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    dh   = 1'b1;
                    pcwe = 1'b0;
                end else begin
                    pch   = 1'b1;
                    flush = 1'b1;
                    if (branch_taken && MULTI_FLUSH) begin
                        cnt_d = FLUSH_RELOAD;
                    end else if (branch_taken || cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            HALT: begin
                dh    = 1'b1;
                pcwe  = 1'b0;
                flush = 1'b1;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase

        stall_d = stall_q;
        if ((dh || pch) && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Outputs are forced low for the whole reset assertion, not just after it.
    assign data_hazard  = rst_n & dh;
    assign PC_hazard    = rst_n & pch;
    assign call         = rst_n & call_c;
    assign pc_write_en  = rst_n & pcwe;
    assign idex_flush   = rst_n & flush;
    assign halted       = rst_n & (state_q == HALT);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level behavioural model checked
// every negedge, plus hand-computed literal expectations at key points.
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ifid_instr = 16'h0000;
    logic        idex_mem_read = 1'b0;
    logic [3:0]  idex_rd = 4'd0;
    logic        branch_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic        data_hazard, PC_hazard, call, pc_write_en, idex_flush, halted;
    logic [15:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CALL_OP(4'hD), .HLT_INSTR(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .data_hazard(data_hazard), .PC_hazard(PC_hazard), .call(call),
        .pc_write_en(pc_write_en), .idex_flush(idex_flush), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dh, pch, cl, pcwe, fl, hlt, halt_fire;
    } exp_t;

    // Model state: remaining flush cycles, halted flag, call mask, stall tally.
    int m_flush_left = 0;
    int m_stall = 0;
    bit m_halted = 1'b0;
    bit m_mask = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        bit lu;
        e = '0;
        if (!rst_n) return e;
        lu = idex_mem_read && idex_rd != 4'd0 &&
             (idex_rd == ifid_instr[7:4] || idex_rd == ifid_instr[3:0]);
        if (m_halted) begin
            e.dh = 1; e.fl = 1; e.hlt = 1;
        end else if (mem_busy) begin
            e.dh = 1;
        end else if (branch_taken || m_flush_left > 0) begin
            e.pch = 1; e.fl = 1; e.pcwe = 1;
        end else if (lu) begin
            e.dh = 1; e.fl = 1;
        end else if (!m_mask && ifid_instr == 16'hFFFF) begin
            e.dh = 1; e.fl = 1; e.halt_fire = 1;
        end else if (!m_mask && ifid_instr[15:12] == 4'hD) begin
            e.cl = 1; e.pcwe = 1;
        end else begin
            e.pcwe = 1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_update
        exp_t e;
        if (!rst_n) begin
            m_flush_left <= 0;
            m_stall      <= 0;
            m_halted     <= 1'b0;
            m_mask       <= 1'b0;
        end else begin
            e = model_out();
            if ((e.dh || e.pch) && m_stall < 65535) m_stall <= m_stall + 1;
            if (!m_halted && !mem_busy) begin
                if (branch_taken) m_flush_left <= FC - 1;
                else if (m_flush_left > 0) m_flush_left <= m_flush_left - 1;
                m_mask <= e.cl;
                if (e.halt_fire) m_halted <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        e = model_out();
        chk("data_hazard", {15'd0, data_hazard}, {15'd0, e.dh});
        chk("PC_hazard",   {15'd0, PC_hazard},   {15'd0, e.pch});
        chk("call",        {15'd0, call},        {15'd0, e.cl});
        chk("pc_write_en", {15'd0, pc_write_en}, {15'd0, e.pcwe});
        chk("idex_flush",  {15'd0, idex_flush},  {15'd0, e.fl});
        chk("halted",      {15'd0, halted},      {15'd0, e.hlt});
        chk("stall_cycles", stall_cycles, 16'(m_stall));
    end

    task automatic drive(input logic [15:0] i, input logic mr, input logic [3:0] rd,
                         input logic br, input logic mb);
        ifid_instr    = i;
        idex_mem_read = mr;
        idex_rd       = rd;
        branch_taken  = br;
        mem_busy      = mb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("reset_pcwe", {15'd0, pc_write_en}, 16'd0);
        chk("reset_halted", {15'd0, halted}, 16'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("run_default_pcwe", {15'd0, pc_write_en}, 16'd1);
        chk("run_default_stall", stall_cycles, 16'd0);
        tick();

        // load-use: 16'h1234 fields 3 and 4, load writes r3
        drive(16'h1234, 1, 4'd3, 0, 0);
        chk("lu_dh", {15'd0, data_hazard}, 16'd1);
        chk("lu_pcwe", {15'd0, pc_write_en}, 16'd0);
        chk("lu_flush", {15'd0, idex_flush}, 16'd1);
        tick();
        drive(16'h1234, 0, 4'd3, 0, 0);
        chk("lu_clear_dh", {15'd0, data_hazard}, 16'd0);
        chk("lu_stall_count", stall_cycles, 16'd1);
        tick();
        drive(16'h1234, 1, 4'd0, 0, 0);
        chk("lu_rd0_dh", {15'd0, data_hazard}, 16'd0);
        chk("lu_rd0_pcwe", {15'd0, pc_write_en}, 16'd1);
        tick();

        // single branch: two flush cycles
        drive(16'h0000, 0, 4'd0, 1, 0);
        chk("br_c1_pch", {15'd0, PC_hazard}, 16'd1);
        tick();
        drive(16'h0000, 0, 4'd0, 0, 0);
        chk("br_c2_pch", {15'd0, PC_hazard}, 16'd1);
        tick();
        chk("br_done_pch", {15'd0, PC_hazard}, 16'd0);
        tick();

        // second branch in cycle 2 extends to three
        drive(16'h0000, 0, 4'd0, 1, 0);
        tick();
        drive(16'h0000, 0, 4'd0, 1, 0);
        chk("br2_c2_pch", {15'd0, PC_hazard}, 16'd1);
        tick();
        drive(16'h0000, 0, 4'd0, 0, 0);
        chk("br2_c3_pch", {15'd0, PC_hazard}, 16'd1);
        tick();
        chk("br2_done_pch", {15'd0, PC_hazard}, 16'd0);
        tick();

        // mem_busy during flush freezes it for 3 cycles
        drive(16'h0000, 0, 4'd0, 1, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(16'h0000, 0, 4'd0, 0, 1);
            chk("busy_dh", {15'd0, data_hazard}, 16'd1);
            chk("busy_pcwe", {15'd0, pc_write_en}, 16'd0);
            tick();
        end
        drive(16'h0000, 0, 4'd0, 0, 0);
        chk("busy_resume_pch", {15'd0, PC_hazard}, 16'd1);
        tick();
        chk("busy_done_pch", {15'd0, PC_hazard}, 16'd0);
        tick();

        // call held two cycles pulses once
        drive(16'hD012, 0, 4'd0, 0, 0);
        chk("call_c1", {15'd0, call}, 16'd1);
        tick();
        chk("call_c2_masked", {15'd0, call}, 16'd0);
        chk("call_c2_pcwe", {15'd0, pc_write_en}, 16'd1);
        tick();

        // no-op never halts
        drive(16'hF000, 0, 4'd0, 0, 0);
        tick();
        tick();
        chk("nop_not_halted", {15'd0, halted}, 16'd0);

        // halt, then toggle inputs long enough to saturate the stall counter
        drive(16'hFFFF, 0, 4'd0, 0, 0);
        chk("halt_pre", {15'd0, halted}, 16'd0);
        chk("halt_dh", {15'd0, data_hazard}, 16'd1);
        tick();
        chk("halt_set", {15'd0, halted}, 16'd1);
        for (int k = 0; k < 65560; k++) begin
            drive(16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        chk("halt_held", {15'd0, halted}, 16'd1);
        chk("stall_saturated", stall_cycles, 16'hFFFF);
        tick();
        chk("stall_no_wrap", stall_cycles, 16'hFFFF);

        // async reset mid-halt
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_stall", stall_cycles, 16'd0);
        drive(16'hF000, 0, 4'd0, 0, 0);
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        chk("post_rst_pcwe", {15'd0, pc_write_en}, 16'd1);

        // async reset mid-flush
        drive(16'h0000, 0, 4'd0, 1, 0);
        tick();
        drive(16'h0000, 0, 4'd0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_flush_pch", {15'd0, PC_hazard}, 16'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_flush_pch", {15'd0, PC_hazard}, 16'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the front of the 5-stage pipeline. It decides, every cycle, whether the IF/ID register advances, holds, or is squashed to the 16'hF000 no-op. It also gates the PC write, bubbles ID/EX, sequences branch flushes and call squashes, and latches the halt condition. It sits between the decode-stage instruction, the EX-stage load and branch status, and the IF/ID, PC and ID/EX control inputs.

## Interface
- FLUSH_CYCLES, 2: bubble cycles after a taken branch, legal 1..7
- CALL_OP, 4'hD: opcode (instr[15:12]) identifying a call
- HLT_INSTR, 16'hFFFF: full 16-bit halt encoding (distinct from no-op 16'hF000)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifid_instr  in  16  instruction currently in decode (IF/ID instruction_out)
- idex_mem_read  in  1  instruction in EX is a load
- idex_rd  in  4  destination register of the EX instruction
- branch_taken  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; freeze whole pipe
- data_hazard  out  1  hold IF/ID contents
- PC_hazard  out  1  load no-op into IF/ID instruction
- call  out  1  call squash to IF/ID
- pc_write_en  out  1  PC register update enable
- idex_flush  out  1  insert bubble into ID/EX
- halted  out  1  core halted
- stall_cycles  out  16  saturating count of cycles with data_hazard or PC_hazard high

## Operation
- States: RUN, FLUSH, CALL_SQ, HALT. The state register, the 3-bit flush counter and stall_cycles are the only flops.
- All control outputs are combinational from the current state and inputs. halted = (state == HALT).
- While rst_n is low, every output is 0.
- Default in RUN with no event: data_hazard=0, PC_hazard=0, call=0, pc_write_en=1, idex_flush=0.
- Priority when in RUN, highest first:
  - mem_busy: data_hazard=1, pc_write_en=0, idex_flush=0. State and counter are unchanged.
  - branch_taken: PC_hazard=1, idex_flush=1, pc_write_en=1. If FLUSH_CYCLES==1, stay in RUN; otherwise go to FLUSH with counter = FLUSH_CYCLES-1.
  - load-use: idex_mem_read && idex_rd!=0 && (idex_rd==ifid_instr[7:4] || idex_rd==ifid_instr[3:0]). Response: data_hazard=1, pc_write_en=0, idex_flush=1. Stay in RUN; the hazard clears once the load leaves EX.
  - halt: ifid_instr==HLT_INSTR. Response: data_hazard=1, pc_write_en=0, idex_flush=1, next state HALT.
  - call: ifid_instr[15:12]==CALL_OP. Response: call=1, pc_write_en=1, next state CALL_SQ.
- FLUSH:
  - Outputs: PC_hazard=1, idex_flush=1, pc_write_en=1.
  - Counter decrements each cycle; go to RUN when it reaches 1.
  - branch_taken reloads the counter to FLUSH_CYCLES-1.
  - mem_busy overrides outputs as in RUN and freezes the counter.
- CALL_SQ:
  - Call detection is masked so the same call never pulses twice.
  - RUN priorities apply otherwise, except that halt is also masked.
  - Next state is RUN unless branch_taken, which goes to FLUSH.
- HALT:
  - Outputs: data_hazard=1, pc_write_en=0, idex_flush=1, halted=1.
  - All inputs are ignored. Exit is by reset only.
- stall_cycles increments on each clk edge where data_hazard|PC_hazard, and holds at 16'hFFFF.

## Timing
- Decisions are combinational in the current cycle and take effect at the next rising clk edge in IF/ID, PC and ID/EX.
- Load-use stall costs exactly 1 cycle when mem_busy is low.
- A taken branch produces FLUSH_CYCLES consecutive cycles of PC_hazard=1, starting in the cycle branch_taken is seen.
- call is high for exactly 1 cycle per decoded call.
- halted rises on the clk edge following HLT_INSTR in decode.
- Asynchronous reset mid-flush or mid-halt forces RUN, counter 0 and stall_cycles 0 immediately. The first active edge after rst_n rises behaves as RUN.

## Test plan
- Load-use stall: idex_mem_read=1, idex_rd=3, ifid_instr=16'h1234 (rt=4, rs=3) -> one cycle of data_hazard=1, pc_write_en=0, idex_flush=1. With idex_rd=0, the same stimulus produces no stall.
- Branch flush, FLUSH_CYCLES=2: branch_taken pulse -> PC_hazard=1 for exactly 2 cycles, then RUN defaults. A second branch_taken in the 2nd cycle extends the flush to 3 cycles total.
- mem_busy priority: hold mem_busy=1 for 3 cycles during FLUSH -> data_hazard=1, pc_write_en=0, and the counter frozen. The flush then completes its remaining cycles.
- Call: ifid_instr=16'hD012 held for 2 cycles -> call=1 only in cycle 1, then CALL_SQ masks cycle 2.
- Halt and reset: ifid_instr=16'hFFFF -> halted=1 next edge and stays high while inputs toggle. Asserting rst_n low mid-halt gives halted=0 and stall_cycles=0 asynchronously. ifid_instr=16'hF000 never halts.
- Counter saturation: force 70000 stall cycles -> stall_cycles reads 16'hFFFF and does not wrap.
